// File: rtl/bayer_mosaic.sv
// bayer_mosaic: reads the R/G/B plane memories in raster order and emits one Bayer sample per pixel over valid/ready.
// Defining FRAME_MARK_EN adds out_sof/out_eol markers that travel through the output FIFO with each sample.
//
// state | meaning
// IDLE  | waiting for start; no reads outstanding, output FIFO empty
// RUN   | issuing plane reads and streaming samples
// FIN   | last sample accepted; done pulses for this one cycle
module bayer_mosaic #(
    parameter int DW = 8,
    parameter int XW = 7,
    parameter int YW = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             rd_r,
    output logic [XW+YW-1:0] addr_r,
    input  logic [DW-1:0]    rdata_r,
    output logic             rd_g,
    output logic [XW+YW-1:0] addr_g,
    input  logic [DW-1:0]    rdata_g,
    output logic             rd_b,
    output logic [XW+YW-1:0] addr_b,
    input  logic [DW-1:0]    rdata_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    data_out,
`ifdef FRAME_MARK_EN
    output logic             out_sof,
    output logic             out_eol,
`endif
    output logic             busy,
    output logic             done
);

    localparam int AW = XW + YW;
`ifdef FRAME_MARK_EN
    localparam int MW = DW + 2;
`else
    localparam int MW = DW;
`endif
    localparam logic [AW:0] FRAME_N  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LAST_CNT = FRAME_N - 1'b1;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    logic [AW:0]   p;
    logic [AW:0]   cnt;
    logic [1:0]    rd_ch;
    logic [1:0]    ret_ch;
    logic          ret_v;
`ifdef FRAME_MARK_EN
    logic          rd_sof, rd_eol;
    logic          ret_sof, ret_eol;
`endif
    logic [MW-1:0] fifo_mem [2];
    logic          wptr;
    logic          rptr;
    logic [1:0]    count;

    logic [DW-1:0] ret_data;
    logic [MW-1:0] ret_word;
    logic [MW-1:0] out_word;
    logic          rd_any;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          fifo_pop;
    logic [1:0]    count_next;
    logic [2:0]    credit_use;
    logic          issue_ok;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [1:0]    iss_ch;
    logic          last_hs;

    always_comb begin
        rd_any = rd_r | rd_g | rd_b;
        case (ret_ch)
            CH_R:    ret_data = rdata_r;
            CH_B:    ret_data = rdata_b;
            default: ret_data = rdata_g;
        endcase
`ifdef FRAME_MARK_EN
        ret_word = {ret_sof, ret_eol, ret_data};
`else
        ret_word = ret_data;
`endif
        // Returning data bypasses the empty FIFO so the first sample appears two cycles after start.
        out_valid = (count != 2'd0) | ret_v;
        if (count != 2'd0)
            out_word = fifo_mem[rptr];
        else if (ret_v)
            out_word = ret_word;
        else
            out_word = '0;

        pop        = out_valid & out_ready;
        bypass     = pop & (count == 2'd0);
        push       = ret_v & ~bypass;
        fifo_pop   = pop & (count != 2'd0);
        count_next = count + {1'b0, push} - {1'b0, fifo_pop};

        // The read on the bus now lands next cycle, so it already holds a credit.
        credit_use = {1'b0, count_next} + {2'b00, rd_any};
        issue_ok   = (state == RUN) & ~p[AW] & (credit_use < 3'd2);
        iss_en     = ((state == IDLE) & start) | issue_ok;
        iss_addr   = (state == IDLE) ? '0 : p[AW-1:0];

        if (iss_addr[0] & ~iss_addr[XW])
            iss_ch = CH_R;
        else if (~iss_addr[0] & iss_addr[XW])
            iss_ch = CH_B;
        else
            iss_ch = CH_G;

        last_hs = pop & (cnt == LAST_CNT);
    end

    assign data_out = out_word[DW-1:0];
`ifdef FRAME_MARK_EN
    assign out_sof  = out_word[DW+1];
    assign out_eol  = out_word[DW];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            p           <= '0;
            cnt         <= '0;
            rd_r        <= 1'b0;
            rd_g        <= 1'b0;
            rd_b        <= 1'b0;
            addr_r      <= '0;
            addr_g      <= '0;
            addr_b      <= '0;
            rd_ch       <= CH_G;
            ret_ch      <= CH_G;
            ret_v       <= 1'b0;
`ifdef FRAME_MARK_EN
            rd_sof      <= 1'b0;
            rd_eol      <= 1'b0;
            ret_sof     <= 1'b0;
            ret_eol     <= 1'b0;
`endif
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            count       <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_r   <= 1'b0;
            rd_g   <= 1'b0;
            rd_b   <= 1'b0;
            done   <= 1'b0;
            ret_v  <= rd_any;
            ret_ch <= rd_ch;
`ifdef FRAME_MARK_EN
            ret_sof <= rd_sof;
            ret_eol <= rd_eol;
`endif
            if (push) begin
                fifo_mem[wptr] <= ret_word;
                wptr           <= ~wptr;
            end
            if (fifo_pop)
                rptr <= ~rptr;
            count <= count_next;

            if (iss_en) begin
                rd_ch <= iss_ch;
`ifdef FRAME_MARK_EN
                rd_sof <= (iss_addr == '0);
                rd_eol <= &iss_addr[XW-1:0];
`endif
                case (iss_ch)
                    CH_R: begin
                        rd_r   <= 1'b1;
                        addr_r <= iss_addr;
                    end
                    CH_B: begin
                        rd_b   <= 1'b1;
                        addr_b <= iss_addr;
                    end
                    default: begin
                        rd_g   <= 1'b1;
                        addr_g <= iss_addr;
                    end
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        p     <= {{AW{1'b0}}, 1'b1};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (issue_ok)
                        p <= p + 1'b1;
                    if (pop)
                        cnt <= cnt + 1'b1;
                    if (last_hs) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bayer_mosaic.sv
// Testbench for bayer_mosaic: plane memories modelled as arrays, expected stream derived from the Bayer pattern rule.
// Cycle n below is the cycle whose inputs are driven, and whose outputs are observed, at negedge n; cycle 0 is the start cycle.
module tb_bayer_mosaic;

    localparam int DW = 8;
    localparam int XW = 7;
    localparam int YW = 7;
    localparam int AW = XW + YW;
    localparam int N  = 1 << AW;
    localparam int W  = 1 << XW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          rd_r, rd_g, rd_b, out_valid, busy, done;
    logic [AW-1:0] addr_r, addr_g, addr_b;
    logic [DW-1:0] rdata_r = '0, rdata_g = '0, rdata_b = '0;
    logic [DW-1:0] data_out;
`ifdef FRAME_MARK_EN
    logic          out_sof, out_eol;
`endif

    logic [DW-1:0] mem_r [N];
    logic [DW-1:0] mem_g [N];
    logic [DW-1:0] mem_b [N];
    logic [DW-1:0] got [N];
    logic          got_sof [N];
    logic          got_eol [N];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc, iss_k, first_rd, first_valid, last_hs, done_cyc, done_cnt;
    int   stall_err, issue_err, max_out, multi_rd;
    logic busy_after, timed_out;

    bayer_mosaic #(.DW(DW), .XW(XW), .YW(YW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_r      (rd_r),
        .addr_r    (addr_r),
        .rdata_r   (rdata_r),
        .rd_g      (rd_g),
        .addr_g    (addr_g),
        .rdata_g   (rdata_g),
        .rd_b      (rd_b),
        .addr_b    (addr_b),
        .rdata_b   (rdata_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef FRAME_MARK_EN
        .out_sof   (out_sof),
        .out_eol   (out_eol),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read plane memories: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (rd_r) rdata_r <= mem_r[addr_r];
        if (rd_g) rdata_g <= mem_g[addr_g];
        if (rd_b) rdata_b <= mem_b[addr_b];
    end

    // 0 = R, 1 = G, 2 = B for raster pixel k.
    function automatic int exp_chan(input int k);
        int x, y;
        x = k % W;
        y = k / W;
        if ((x % 2 == 1) && (y % 2 == 0)) return 0;
        if ((x % 2 == 0) && (y % 2 == 1)) return 2;
        return 1;
    endfunction

    function automatic logic [DW-1:0] exp_sample(input int k);
        case (exp_chan(k))
            0:       return mem_r[k];
            2:       return mem_b[k];
            default: return mem_g[k];
        endcase
    endfunction

    task automatic fill_random;
        for (int k = 0; k < N; k++) begin
            mem_r[k] = 8'($urandom);
            mem_g[k] = 8'($urandom);
            mem_b[k] = 8'($urandom);
        end
    endtask

    // Drives one frame and records what the consumer sees; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic run_stream(input int mode, input int sp1, input int sp2, input int abort_after, input int limit);
        int   n;
        logic prev_stall;
        logic [DW-1:0] prev_data;
        for (int k = 0; k < N; k++) begin
            got[k] = 'x;
            got_sof[k] = 1'b0;
            got_eol[k] = 1'b0;
        end
        acc = 0; iss_k = 0; first_rd = -1; first_valid = -1; last_hs = -1;
        done_cyc = -1; done_cnt = 0; stall_err = 0; issue_err = 0; max_out = 0;
        multi_rd = 0; busy_after = 1'b1; timed_out = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1;
        out_ready = (mode == 1) ? 1'b1 : 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n > limit) begin
                timed_out = 1'b1;
                break;
            end
            start = (n == sp1) || (n == sp2);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase

            if (rd_r || rd_g || rd_b) begin
                if (first_rd < 0) first_rd = n;
                if (int'(rd_r) + int'(rd_g) + int'(rd_b) > 1) multi_rd++;
                if (iss_k >= N) issue_err++;
                else case (exp_chan(iss_k))
                    0:       if (!rd_r || int'(addr_r) != iss_k) issue_err++;
                    2:       if (!rd_b || int'(addr_b) != iss_k) issue_err++;
                    default: if (!rd_g || int'(addr_g) != iss_k) issue_err++;
                endcase
                iss_k++;
                if (iss_k - acc > max_out) max_out = iss_k - acc;
            end

            if (prev_stall && (out_valid !== 1'b1 || data_out !== prev_data)) stall_err++;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = n;
            if (out_valid === 1'b1 && out_ready) begin
                if (acc < N) begin
                    got[acc] = data_out;
`ifdef FRAME_MARK_EN
                    got_sof[acc] = out_sof;
                    got_eol[acc] = out_eol;
`endif
                end
                acc++;
                last_hs = n;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = data_out;

            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc >= 0 && n == done_cyc + 1) busy_after = busy;
            if (abort_after > 0 && acc >= abort_after) break;
            if (done_cyc >= 0 && n >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rd_r, rd_g, rd_b, out_valid, busy, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 000000", {rd_r, rd_g, rd_b, out_valid, busy, done});
        end
        n_cmp++;
        if ({addr_r, addr_g, addr_b, data_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got addr %h/%h/%h data %h expected all zero", addr_r, addr_g, addr_b, data_out);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rd_r, rd_g, rd_b, out_valid, busy, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL idle_no_start: got %b expected 000000", {rd_r, rd_g, rd_b, out_valid, busy, done});
        end
    endtask

    task automatic test_preload_start_ignore;
        int errs, bad;
        fill_random();
        mem_r[1]   = 8'h11;
        mem_g[0]   = 8'h22;
        mem_b[128] = 8'h33;
        mem_g[129] = 8'h44;
        run_stream(0, 10, 500, 0, N + 100);
        n_cmp++;
        if (timed_out) begin n_bad++; $display("FAIL preload_timeout: got %0d samples expected %0d", acc, N); end
        n_cmp++;
        if (got[0] !== 8'h22) begin n_bad++; $display("FAIL sample0: got %h expected 22", got[0]); end
        n_cmp++;
        if (got[1] !== 8'h11) begin n_bad++; $display("FAIL sample1: got %h expected 11", got[1]); end
        n_cmp++;
        if (got[128] !== 8'h33) begin n_bad++; $display("FAIL sample128: got %h expected 33", got[128]); end
        n_cmp++;
        if (got[129] !== 8'h44) begin n_bad++; $display("FAIL sample129: got %h expected 44", got[129]); end
        errs = 0; bad = 0;
        for (int k = 0; k < N; k++)
            if (got[k] !== exp_sample(k)) begin
                if (errs == 0) bad = k;
                errs++;
            end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL preload_stream: %0d wrong, first #%0d got %h expected %h", errs, bad, got[bad], exp_sample(bad));
        end
        n_cmp++;
        if (acc != N) begin n_bad++; $display("FAIL start_ignore_count: got %0d samples expected %0d", acc, N); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL start_ignore_done: got %0d pulses expected 1", done_cnt); end
        n_cmp++;
        if (issue_err != 0) begin n_bad++; $display("FAIL preload_issue: got %0d bad reads expected 0", issue_err); end
    endtask

    task automatic test_throughput;
        int errs, bad;
        for (int a = 0; a < N; a++) begin
            mem_r[a] = 8'(a + 1);
            mem_g[a] = 8'(a + 2);
            mem_b[a] = 8'(a + 3);
        end
        run_stream(0, -1, -1, 0, N + 100);
        n_cmp++;
        if (timed_out) begin n_bad++; $display("FAIL ramp_timeout: got %0d samples expected %0d", acc, N); end
        n_cmp++;
        if (first_rd != 1) begin n_bad++; $display("FAIL first_read_cycle: got %0d expected 1", first_rd); end
        n_cmp++;
        if (first_valid != 2) begin n_bad++; $display("FAIL first_valid_cycle: got %0d expected 2", first_valid); end
        n_cmp++;
        if (last_hs != N + 1) begin n_bad++; $display("FAIL last_sample_cycle: got %0d expected %0d", last_hs, N + 1); end
        n_cmp++;
        if (done_cyc != N + 2) begin n_bad++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, N + 2); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL ramp_done_pulses: got %0d expected 1", done_cnt); end
        n_cmp++;
        if (busy_after !== 1'b0) begin n_bad++; $display("FAIL busy_after_done: got %b expected 0", busy_after); end
        n_cmp++;
        if (max_out > 2) begin n_bad++; $display("FAIL ramp_outstanding: got %0d expected <=2", max_out); end
        errs = 0; bad = 0;
        for (int k = 0; k < N; k++)
            if (got[k] !== exp_sample(k)) begin
                if (errs == 0) bad = k;
                errs++;
            end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL ramp_stream: %0d wrong, first #%0d got %h expected %h", errs, bad, got[bad], exp_sample(bad));
        end
`ifdef FRAME_MARK_EN
        begin
            int sof_n, eol_n, mark_err;
            sof_n = 0; eol_n = 0; mark_err = 0;
            for (int k = 0; k < N; k++) begin
                if (got_sof[k]) sof_n++;
                if (got_eol[k]) eol_n++;
                if (got_sof[k] !== (k == 0)) mark_err++;
                if (got_eol[k] !== (k % W == W - 1)) mark_err++;
            end
            n_cmp++;
            if (sof_n != 1 || got_sof[0] !== 1'b1) begin n_bad++; $display("FAIL sof_marks: got %0d expected 1 on sample 0", sof_n); end
            n_cmp++;
            if (eol_n != YW * 0 + (N / W)) begin n_bad++; $display("FAIL eol_count: got %0d expected %0d", eol_n, N / W); end
            n_cmp++;
            if (mark_err != 0) begin n_bad++; $display("FAIL mark_position: got %0d misplaced expected 0", mark_err); end
        end
`endif
    endtask

    task automatic test_stall_pattern;
        int errs, bad;
        fill_random();
        run_stream(1, -1, -1, 0, 3 * N);
        n_cmp++;
        if (timed_out) begin n_bad++; $display("FAIL stall_timeout: got %0d samples expected %0d", acc, N); end
        errs = 0; bad = 0;
        for (int k = 0; k < N; k++)
            if (got[k] !== exp_sample(k)) begin
                if (errs == 0) bad = k;
                errs++;
            end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL stall_stream: %0d wrong, first #%0d got %h expected %h", errs, bad, got[bad], exp_sample(bad));
        end
        n_cmp++;
        if (stall_err != 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); end
        n_cmp++;
        if (max_out > 2) begin n_bad++; $display("FAIL stall_outstanding: got %0d expected <=2", max_out); end
        n_cmp++;
        if (multi_rd != 0 || issue_err != 0) begin
            n_bad++;
            $display("FAIL stall_issue: got %0d multi-reads %0d bad reads expected 0", multi_rd, issue_err);
        end
        n_cmp++;
        if (acc != N || done_cnt != 1) begin
            n_bad++;
            $display("FAIL stall_frame: got %0d samples %0d done expected %0d and 1", acc, done_cnt, N);
        end
    endtask

    task automatic test_reset_midframe;
        int errs, bad;
        fill_random();
        run_stream(2, -1, -1, 5001, 4 * N);
        n_cmp++;
        if (timed_out || acc != 5001) begin n_bad++; $display("FAIL midframe_reach: got %0d samples expected 5001", acc); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rd_r, rd_g, rd_b, out_valid, busy, done} !== 6'b0 || {addr_r, addr_g, addr_b, data_out} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_now: got ctrl %b data %h expected zero", {rd_r, rd_g, rd_b, out_valid, busy, done}, data_out);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rd_r, rd_g, rd_b, out_valid, busy, done} !== 6'b0 || {addr_r, addr_g, addr_b, data_out} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_hold: got ctrl %b data %h expected zero", {rd_r, rd_g, rd_b, out_valid, busy, done}, data_out);
        end
        reset = 1'b1;
        @(negedge clk);
        run_stream(2, -1, -1, 300, 4000);
        n_cmp++;
        if (timed_out || acc != 300) begin n_bad++; $display("FAIL restart_reach: got %0d samples expected 300", acc); end
        errs = 0; bad = 0;
        for (int k = 0; k < 300; k++)
            if (got[k] !== exp_sample(k)) begin
                if (errs == 0) bad = k;
                errs++;
            end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL restart_stream: %0d wrong, first #%0d got %h expected %h", errs, bad, got[bad], exp_sample(bad));
        end
        n_cmp++;
        if (issue_err != 0) begin n_bad++; $display("FAIL restart_issue: got %0d bad reads expected 0", issue_err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_preload_start_ignore();
        test_throughput();
        test_stall_pattern();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
